// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between the byte FIFO and the UART transmitter.
// master = consumer issuing pops (the transmitter), slave = the FIFO itself.
interface fifo_uart_tx_if;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_rd_en;

  modport master (input fifo_empty, input fifo_dout, output fifo_rd_en);
  modport slave  (output fifo_empty, output fifo_dout, input fifo_rd_en);
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a byte FIFO: start, 8 data bits LSB first,
// optional even parity, one stop bit, plus a saturating sent-byte counter.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  fifo_uart_tx_if.master     fifo,
  output logic               tx,
  output logic               busy,
  output logic [CNT_W-1:0]   tx_count,
  input  logic               clr_count
);

  localparam int               BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_q;
  logic              parity_q;
  logic              bit_done;
  logic              pop_ok;
  logic              serial;

  assign bit_done = (baud_cnt == BAUD_LAST);
  // Pop decision is only ever taken in IDLE or the last STOP cycle.
  assign pop_ok   = enable && !fifo.fifo_empty;
  assign serial   = (state_q == S_START) || (state_q == S_DATA) ||
                    (state_q == S_PARITY) || (state_q == S_STOP);

  // NOTE: defaults are assigned before the case so no path leaves state_d
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (pop_ok) state_d = S_FETCH;
      S_FETCH:  state_d = S_LOAD;
      S_LOAD:   state_d = S_START;
      S_START:  if (bit_done) state_d = S_DATA;
      S_DATA:   if (bit_done && bit_idx == 3'd7) state_d = PARITY_EN ? S_PARITY : S_STOP;
      S_PARITY: if (bit_done) state_d = S_STOP;
      S_STOP:   if (bit_done) state_d = pop_ok ? S_FETCH : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
    end else begin
      if (state_d != state_q || bit_done) baud_cnt <= '0;
      else if (serial)                    baud_cnt <= baud_cnt + 1'b1;

      if (state_q == S_LOAD) begin
        shift_q  <= fifo.fifo_dout;
        parity_q <= ^fifo.fifo_dout;
      end else if (state_q == S_DATA && bit_done) begin
        shift_q <= {1'b0, shift_q[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // Clear wins over the final-STOP increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                                   tx_count <= '0;
    else if (clr_count)                                         tx_count <= '0;
    else if (state_q == S_STOP && bit_done && tx_count != CNT_MAX) tx_count <= tx_count + 1'b1;
  end

  always_comb begin
    tx = 1'b1;
    case (state_q)
      S_START:  tx = 1'b0;
      S_DATA:   tx = shift_q[0];
      S_PARITY: tx = parity_q;
      default:  tx = 1'b1;
    endcase
  end

  assign busy            = (state_q != S_IDLE);
  assign fifo.fifo_rd_en = (state_q == S_FETCH);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: unit 0 (no parity, 4-bit counter), unit 1 (parity).
// A line monitor decodes frames and compares them against a scoreboard queue.
module tb_fifo_uart_tx;
  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  logic        rst       [2];
  logic        enable    [2];
  logic        clr_count [2];
  logic        wr_en     [2];
  logic [7:0]  wr_data   [2];
  logic        tx        [2];
  logic        busy      [2];
  logic [15:0] txc       [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_u
    localparam bit PE = (g == 1);
    localparam int CW = (g == 0) ? 4 : 16;
    localparam int NB = (g == 1) ? 11 : 10;

    fifo_uart_tx_if fif ();
    logic [CW-1:0] cnt;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(PE), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst[g]),
      .enable    (enable[g]),
      .fifo      (fif),
      .tx        (tx[g]),
      .busy      (busy[g]),
      .tx_count  (cnt),
      .clr_count (clr_count[g])
    );
    assign txc[g] = 16'(cnt);

    // FIFO model with registered read data; writes also feed the scoreboard.
    logic [7:0] mem   [$];
    logic [7:0] exp_q [$];
    logic       empty_r = 1'b1;
    logic [7:0] dout_r  = 8'h00;
    assign fif.fifo_empty = empty_r;
    assign fif.fifo_dout  = dout_r;

    always @(posedge clk) begin
      if (fif.fifo_rd_en && mem.size() > 0) dout_r <= mem.pop_front();
      if (wr_en[g]) begin
        mem.push_back(wr_data[g]);
        exp_q.push_back(wr_data[g]);
      end
      empty_r <= (mem.size() == 0);
    end

    int rd_cnt = 0, rd_bad = 0, last_rd_cyc = 0;
    always @(negedge clk) begin
      if (fif.fifo_rd_en) begin
        rd_cnt      <= rd_cnt + 1;
        last_rd_cyc <= cyc;
        if (fif.fifo_empty) rd_bad <= rd_bad + 1;
      end
    end

    int frames = 0, start_cyc = 0;
    int gap_q [$];

    initial begin : mon
      int         idle;
      logic [NB-1:0] bits;
      logic       stable, aborted;
      logic [7:0] e;
      idle = 0;
      bits = '0;
      forever begin
        @(negedge clk);
        if (!rst[g]) begin idle = 0; continue; end
        if (tx[g])   begin idle++;   continue; end
        gap_q.push_back(idle);
        start_cyc = cyc;
        stable  = 1'b1;
        aborted = 1'b0;
        for (int b = 0; b < NB && !aborted; b++) begin
          for (int k = 0; k < CPB; k++) begin
            if (!(b == 0 && k == 0)) @(negedge clk);
            if (!rst[g]) begin aborted = 1'b1; break; end
            if (k == 0) bits[b] = tx[g];
            else if (tx[g] !== bits[b]) stable = 1'b0;
          end
        end
        idle = 0;
        if (aborted) begin
          // The byte popped for an aborted frame is lost.
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          continue;
        end
        check("bit_stable", stable, 1);
        check("stop_bit", bits[NB-1], 1);
        check("frame_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("data", 32'(bits[8:1]), 32'(e));
          check("bit9", bits[9], PE ? ^e : 1'b1);
        end
        frames = frames + 1;
      end
    end
  end

  function automatic int frames_of(input int u);
    return (u == 0) ? g_u[0].frames : g_u[1].frames;
  endfunction

  task automatic push(input int u, input logic [7:0] b);
    @(negedge clk);
    wr_data[u] = b;
    wr_en[u]   = 1'b1;
    @(negedge clk);
    wr_en[u]   = 1'b0;
  endtask

  task automatic pulse_clr(input int u);
    @(negedge clk);
    clr_count[u] = 1'b1;
    @(negedge clk);
    clr_count[u] = 1'b0;
  endtask

  task automatic wait_frames(input int u, input int n, input int budget, input string tag);
    int k = 0;
    while (frames_of(u) < n && k < budget) begin @(negedge clk); k++; end
    check(tag, 32'(frames_of(u) >= n), 1);
  endtask

  task automatic wait_idle(input int u, input int budget, input string tag);
    int k = 0;
    while (busy[u] && k < budget) begin @(negedge clk); k++; end
    check(tag, busy[u], 0);
  endtask

  task automatic wait_tx_low(input int u, input int budget, input string tag);
    int k = 0;
    while (tx[u] !== 1'b0 && k < budget) begin @(negedge clk); k++; end
    check(tag, tx[u], 0);
  endtask

  task automatic wait_rd0(input int n, input int budget, input string tag);
    int k = 0;
    while (g_u[0].rd_cnt < n && k < budget) begin @(negedge clk); k++; end
    check(tag, 32'(g_u[0].rd_cnt >= n), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, f0, low_cnt;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; enable[i] = 1'b0; clr_count[i] = 1'b0;
      wr_en[i] = 1'b0; wr_data[i] = 8'h00;
    end
    #3;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx[0], 1);
    check("rst_busy", busy[0], 0);
    check("rst_rd_en", g_u[0].fif.fifo_rd_en, 0);
    check("rst_count", txc[0], 0);
    check("rst_tx_par", tx[1], 1);
    rst[0] = 1'b1; rst[1] = 1'b1;
    enable[0] = 1'b1; enable[1] = 1'b1;
    @(negedge clk);

    // Single frame: 0xA5, pop strobe then start bit two cycles later
    push(0, 8'hA5);
    wait_frames(0, 1, 200, "t1_frame");
    wait_idle(0, 20, "t1_idle");
    check("t1_rd_pulses", g_u[0].rd_cnt, 1);
    check("t1_latency", g_u[0].start_cyc - g_u[0].last_rd_cyc, 2);
    check("t1_count", txc[0], 1);

    // Back-to-back frames with a two-cycle gap
    pulse_clr(0);
    check("t2_clr", txc[0], 0);
    g_u[0].gap_q.delete();
    rd0 = g_u[0].rd_cnt;
    f0  = frames_of(0);
    push(0, 8'h00);
    push(0, 8'hFF);
    push(0, 8'h3C);
    wait_frames(0, f0 + 3, 400, "t2_frames");
    wait_idle(0, 20, "t2_idle");
    check("t2_rd_pulses", g_u[0].rd_cnt - rd0, 3);
    check("t2_count", txc[0], 3);
    check("t2_nframes", g_u[0].gap_q.size(), 3);
    check("t2_gap1", g_u[0].gap_q[1], 2);
    check("t2_gap2", g_u[0].gap_q[2], 2);

    // Parity unit: 0x07 (parity 1) then 0x03 (parity 0)
    g_u[1].gap_q.delete();
    push(1, 8'h07);
    push(1, 8'h03);
    wait_frames(1, 2, 300, "t3_frames");
    wait_idle(1, 20, "t3_idle");
    check("t3_gap", g_u[1].gap_q[1], 2);
    check("t3_count", txc[1], 2);
    check("t3_rd_pulses", g_u[1].rd_cnt, 2);

    // Enable dropped mid-frame with a byte still queued
    rd0 = g_u[0].rd_cnt;
    f0  = frames_of(0);
    push(0, 8'h5A);
    push(0, 8'hC3);
    wait_rd0(rd0 + 1, 50, "t4_pop1");
    repeat (10) @(negedge clk);
    enable[0] = 1'b0;
    wait_frames(0, f0 + 1, 100, "t4_frame1");
    wait_idle(0, 20, "t4_idle");
    repeat (20) @(negedge clk);
    check("t4_no_pop", g_u[0].rd_cnt - rd0, 1);
    check("t4_still_idle", busy[0], 0);
    enable[0] = 1'b1;
    wait_frames(0, f0 + 2, 100, "t4_frame2");
    wait_idle(0, 20, "t4_idle2");
    check("t4_pop2", g_u[0].rd_cnt - rd0, 2);
    rd0 = g_u[0].rd_cnt;
    low_cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx[0] !== 1'b1) low_cnt++;
    end
    check("t4_empty_tx_high", low_cnt, 0);
    check("t4_empty_no_pop", g_u[0].rd_cnt - rd0, 0);

    // Async reset during D3 of 0x96 (D3 = 0); 0x69 follows cleanly
    rd0 = g_u[0].rd_cnt;
    f0  = frames_of(0);
    push(0, 8'h96);
    push(0, 8'h69);
    wait_tx_low(0, 50, "t5_start");
    repeat (17) @(negedge clk);
    #2 rst[0] = 1'b0;
    #1;
    check("t5_rst_tx", tx[0], 1);
    check("t5_rst_busy", busy[0], 0);
    check("t5_rst_count", txc[0], 0);
    repeat (3) @(negedge clk);
    rst[0] = 1'b1;
    wait_frames(0, f0 + 1, 200, "t5_frame");
    wait_idle(0, 20, "t5_idle");
    check("t5_count", txc[0], 1);
    check("t5_pops", g_u[0].rd_cnt - rd0, 2);

    // Counter saturation at 0xF, then clear on the final STOP cycle
    pulse_clr(0);
    f0 = frames_of(0);
    for (int i = 0; i < 16; i++) push(0, 8'(i * 17 + 1));
    wait_frames(0, f0 + 16, 16 * 60, "t6_frames");
    wait_idle(0, 20, "t6_idle");
    check("t6_saturate", txc[0], 16'h000F);
    push(0, 8'h81);
    wait_tx_low(0, 50, "t6_start");
    repeat (39) @(negedge clk);
    clr_count[0] = 1'b1;
    @(negedge clk);
    clr_count[0] = 1'b0;
    check("t6_clr_priority", txc[0], 0);
    wait_idle(0, 20, "t6_idle2");
    repeat (3) @(negedge clk);
    check("t6_clr_hold", txc[0], 0);

    check("no_pop_when_empty", g_u[0].rd_bad + g_u[1].rd_bad, 0);
    check("sb_drained0", g_u[0].exp_q.size(), 0);
    check("sb_drained1", g_u[1].exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream consumer of the 16x8 byte FIFO.
- Pops one byte at a time through the FIFO read port and serialises it onto a single UART line: start bit, 8 data bits LSB first, optional even parity, one stop bit.
- Sits between the FIFO and the chip-level TX pad.
- Keeps a running count of transmitted bytes for status readback.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; legal range 2..65535
PARITY_EN, 0, 1 = insert an even-parity bit between D7 and the stop bit
CNT_W, 16, width of the transmitted-byte counter

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
enable  input  1  1 = allowed to start new frames
fifo_empty  input  1  FIFO empty flag
fifo_dout  input  8  FIFO read data, registered in FIFO; valid the cycle after rd_en
fifo_rd_en  output  1  one-cycle pop strobe to FIFO
tx  output  1  serial line, idle high
busy  output  1  1 while any frame is in progress (FETCH..STOP)
tx_count  output  CNT_W  bytes fully transmitted, saturating
clr_count  input  1  synchronous clear of tx_count

Behaviour:
- Reset (rst=0, async): state=IDLE, tx=1, busy=0, fifo_rd_en=0, tx_count=0, baud counter=0, bit index=0, shift register=0.
- All outputs are registered or decoded from state only. No combinational path from inputs to outputs.
- FSM states: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE: tx=1. If enable=1 and fifo_empty=0 at a rising edge, go to FETCH.
- FETCH: exactly one cycle. fifo_rd_en=1 (Moore decode). Always go to LOAD.
- LOAD: one cycle. Capture fifo_dout into the 8-bit shift register. Compute parity as XOR of the byte. Go to START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: tx=shift[0]. Shift right every CLKS_PER_BIT cycles. 8 bits total. Bit index runs 0..7.
- After bit 7: go to PARITY if PARITY_EN=1, else go to STOP.
- PARITY: tx=even parity bit for CLKS_PER_BIT cycles.
- STOP: tx=1 for CLKS_PER_BIT cycles. tx_count increments on the final STOP cycle.
- Leaving STOP: if enable=1 and fifo_empty=0, go directly to FETCH; else go to IDLE.
- Back-to-back inter-frame gap is exactly 2 cycles of tx=1 (FETCH and LOAD).
- Baud counter: counts 0..CLKS_PER_BIT-1. Reloads to 0 on every state change and every bit boundary. Width is $clog2(CLKS_PER_BIT).
- Frame length in cycles:
  - (10+PARITY_EN)*CLKS_PER_BIT for the serial portion.
  - Plus 2 cycles (FETCH, LOAD) from the IDLE-exit edge to the first start-bit cycle.
- busy=1 in every state except IDLE.
- enable deasserted mid-frame: the current frame completes unchanged, then the FSM returns to IDLE. No further pops.
- fifo_empty rising during a frame: no effect on the current frame.
- fifo_rd_en is never asserted while fifo_empty=1 in the same cycle. The decision to pop is made on fifo_empty sampled in IDLE or the last STOP cycle.
- tx_count:
  - Saturates at all-ones.
  - clr_count=1 forces 0 on the next edge and takes priority over the increment.
- Reset asserted mid-frame: tx goes to 1 immediately (async). The frame is aborted and tx_count is unchanged at reset value 0. The byte already popped is lost; this is accepted.
- tx never glitches within a bit period: it changes only at state or bit boundaries.

Test Plan:
1. Reset, then 1-byte frame (CLKS_PER_BIT=4, PARITY_EN=0). Reset with rst=0, fifo_empty=1, then release. Expect tx=1, busy=0, fifo_rd_en=0, tx_count=0. Load 0xA5 into the FIFO with enable=1. Expect one fifo_rd_en pulse, then 2 cycles later tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total). tx_count=1 and busy=0 after STOP.
2. Back-to-back bytes. Load 0x00, 0xFF, 0x3C. Expect three frames, each gap exactly 2 idle-high cycles, exactly 3 rd_en pulses, tx_count=3. The serial stream decodes to 0x00, 0xFF, 0x3C.
3. Parity (PARITY_EN=1, CLKS_PER_BIT=4). Send 0x07, then 0x03. Parity bit is 1 for 0x07 and 0 for 0x03. Each frame is 44 serial cycles.
4. Enable and empty gating. Deassert enable during DATA of byte 1 with byte 2 still queued. Byte 1 completes, the FSM goes to IDLE, and there is no rd_en. Re-enable: byte 2 is sent. Then with the FIFO empty and enable=1 for 100 cycles: tx=1 and no rd_en.
5. Async reset mid-frame. Assert rst=0 during bit D3, off a clock edge. tx=1 and busy=0 immediately. After release with the FIFO still non-empty, the next frame starts cleanly with a full start bit.
6. Counter edges (CNT_W=4). Send 16 bytes: tx_count saturates at 0xF. Assert clr_count in the same cycle as the final STOP cycle of the next frame: tx_count=0.
